// File: rtl/fir_stream_feeder.sv
// fir_stream_feeder
// Streams cfg_length consecutive 32-bit words from the data SRAM into the
// FIR slave AXI-Stream port. SRAM reads are throttled so that the 2-entry
// skid FIFO can never overflow: a read is only issued when the words already
// buffered plus the one in flight, less the beat leaving this cycle, leave room.
module fir_stream_feeder #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pLEN_WIDTH  = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   cfg_start,
    input  logic [pADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [pLEN_WIDTH-1:0]  cfg_length,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_en,
    output logic [pADDR_WIDTH-1:0] ram_addr,
    input  logic [pDATA_WIDTH-1:0] ram_rdata,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [pLEN_WIDTH-1:0]  LEN_ONE   = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pLEN_WIDTH-1:0]  LEN_ZERO  = {pLEN_WIDTH{1'b0}};
    localparam logic [pADDR_WIDTH-1:0] ADDR_ZERO = {pADDR_WIDTH{1'b0}};
    localparam logic [pADDR_WIDTH-1:0] WORD_MASK = {{(pADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [pDATA_WIDTH-1:0] DATA_ZERO = {pDATA_WIDTH{1'b0}};

    state_t                   state_r;
    state_t                   state_next_s;

    logic [pADDR_WIDTH-1:0]   base_r;
    logic [pLEN_WIDTH-1:0]    len_r;
    logic [pLEN_WIDTH-1:0]    rd_cnt_r;
    logic [pLEN_WIDTH-1:0]    tx_cnt_r;
    logic                     inflight_r;

    logic [pDATA_WIDTH-1:0]   fifo_mem_r [2];
    logic                     wr_ptr_r;
    logic                     rd_ptr_r;
    logic [1:0]               occ_r;

    logic                     start_s;
    logic                     valid_s;
    logic                     pop_s;
    logic                     push_s;
    logic                     last_s;
    logic [2:0]               level_s;
    logic                     issue_s;
    logic [pADDR_WIDTH-1:0]   rd_addr_s;

    // Datapath decode: handshake, FIFO level after this cycle, read issue and address
    always_comb begin
        start_s   = 1'b0;
        valid_s   = 1'b0;
        pop_s     = 1'b0;
        push_s    = 1'b0;
        last_s    = 1'b0;
        level_s   = 3'd0;
        issue_s   = 1'b0;
        rd_addr_s = ADDR_ZERO;
        if (state_r == ST_IDLE) begin
            start_s = cfg_start;
        end else begin
            start_s = 1'b0;
        end
        if (state_r == ST_RUN) begin
            valid_s = (occ_r != 2'd0);
        end else begin
            valid_s = 1'b0;
        end
        pop_s     = valid_s & ss_tready;
        push_s    = inflight_r;
        // length is never zero while in RUN, so length-1 cannot underflow here
        last_s    = (tx_cnt_r == (len_r - LEN_ONE));
        level_s   = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        rd_addr_s = base_r + {rd_cnt_r[pADDR_WIDTH-3:0], 2'b00};
        if ((state_r == ST_RUN) && (rd_cnt_r < len_r) && (level_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (cfg_length == LEN_ZERO) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: status, SRAM request and stream beat
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        ram_en    = 1'b0;
        ram_addr  = ADDR_ZERO;
        ss_tvalid = 1'b0;
        ss_tdata  = DATA_ZERO;
        ss_tlast  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_RUN: begin
                busy      = 1'b1;
                ram_en    = issue_s;
                ss_tvalid = valid_s;
                ss_tlast  = valid_s & last_s;
                if (issue_s) begin
                    ram_addr = rd_addr_s;
                end else begin
                    ram_addr = ADDR_ZERO;
                end
                if (valid_s) begin
                    ss_tdata = fifo_mem_r[rd_ptr_r];
                end else begin
                    ss_tdata = DATA_ZERO;
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Latch base address (word aligned) and length only when a start is accepted
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            base_r <= ADDR_ZERO;
            len_r  <= LEN_ZERO;
        end else if (start_s) begin
            base_r <= cfg_base_addr & WORD_MASK;
            len_r  <= cfg_length;
        end else begin
            base_r <= base_r;
            len_r  <= len_r;
        end
    end

    // Read-issue and transmit counters, plus the one-cycle read-in-flight flag
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            rd_cnt_r   <= LEN_ZERO;
            tx_cnt_r   <= LEN_ZERO;
            inflight_r <= 1'b0;
        end else if (start_s) begin
            rd_cnt_r   <= LEN_ZERO;
            tx_cnt_r   <= LEN_ZERO;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                rd_cnt_r <= rd_cnt_r + LEN_ONE;
            end else begin
                rd_cnt_r <= rd_cnt_r;
            end
            if (pop_s) begin
                tx_cnt_r <= tx_cnt_r + LEN_ONE;
            end else begin
                tx_cnt_r <= tx_cnt_r;
            end
        end
    end

    // 2-entry FIFO: SRAM word captured the cycle it is valid, head drives the stream
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            fifo_mem_r[0] <= DATA_ZERO;
            fifo_mem_r[1] <= DATA_ZERO;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            occ_r         <= 2'd0;
        end else if (start_s) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= ram_rdata;
                wr_ptr_r             <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            occ_r <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

endmodule

// File: tb/tb_fir_stream_feeder.sv
// Directed bench for fir_stream_feeder: a table of transfers applied in a loop
// plus hand-written sequences for reset behaviour. A behavioural SRAM with
// one-cycle read latency feeds the DUT; mem[i] = i+1.
module tb_fir_stream_feeder;

    logic        clk = 1'b0;
    logic        axis_rst;
    logic        cfg_start;
    logic [11:0] cfg_base_addr;
    logic [15:0] cfg_length;
    logic        busy;
    logic        done;
    logic        ram_en;
    logic [11:0] ram_addr;
    logic [31:0] ram_rdata;
    logic        ss_tvalid;
    logic [31:0] ss_tdata;
    logic        ss_tlast;
    logic        ss_tready;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] base;
        logic [15:0] len;
        int          ready_mode;  // 0: always ready, 1: ready in cycles 0,3,6,...
        int          mid_start;   // cycle of a stray cfg_start (0 = none)
        int          exp_done;    // cycle of the done pulse, start cycle = 0
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    fir_stream_feeder dut (
        .axis_clk      (clk),
        .axis_rst      (axis_rst),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_length    (cfg_length),
        .busy          (busy),
        .done          (done),
        .ram_en        (ram_en),
        .ram_addr      (ram_addr),
        .ram_rdata     (ram_rdata),
        .ss_tvalid     (ss_tvalid),
        .ss_tdata      (ss_tdata),
        .ss_tlast      (ss_tlast),
        .ss_tready     (ss_tready)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    // SRAM model: data valid the cycle after ram_en
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[11:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model_addr(input logic [11:0] base, input int k);
        logic [11:0] a;
        a = (base & 12'hFFC) + 12'(k * 4);
        return a;
    endfunction

    function automatic logic [31:0] model_data(input logic [11:0] base, input int k);
        logic [11:0] a;
        a = model_addr(base, k);
        return mem[a[11:2]];
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        chk({tag, "_ram_addr"}, {20'd0, ram_addr}, 32'd0);
        chk({tag, "_tvalid"}, {31'd0, ss_tvalid}, 32'd0);
        chk({tag, "_tdata"}, ss_tdata, 32'd0);
        chk({tag, "_tlast"}, {31'd0, ss_tlast}, 32'd0);
    endtask

    // Runs one transfer from the start cycle through the done pulse and checks it
    task automatic run_vec(input vec_t v);
        int          cyc;
        int          beats;
        int          reads;
        bit          fin;
        logic        pv;
        logic        pr;
        logic        pl;
        logic [31:0] pd;
        cyc   = 0;
        beats = 0;
        reads = 0;
        fin   = 1'b0;
        pv    = 1'b0;
        pr    = 1'b0;
        pl    = 1'b0;
        pd    = 32'd0;
        @(posedge clk); #1;
        cfg_start     = 1'b1;
        cfg_base_addr = v.base;
        cfg_length    = v.len;
        ss_tready     = 1'b1;
        while (!fin) begin
            @(posedge clk); #1;
            cyc++;
            cfg_start = (v.mid_start == cyc);
            if (v.mid_start == cyc) begin
                cfg_base_addr = 12'h100;
                cfg_length    = 16'd5;
            end
            ss_tready = (v.ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(negedge clk);
            chk("busy_active", {31'd0, busy}, 32'd1);
            if (pv && !pr) begin
                chk("hold_tvalid", {31'd0, ss_tvalid}, 32'd1);
                chk("hold_tdata", ss_tdata, pd);
                chk("hold_tlast", {31'd0, ss_tlast}, {31'd0, pl});
            end
            if (ram_en) begin
                chk("ram_addr", {20'd0, ram_addr}, {20'd0, model_addr(v.base, reads)});
                reads++;
            end
            if (ss_tvalid && ss_tready) begin
                chk("tdata", ss_tdata, model_data(v.base, beats));
                chk("tlast", {31'd0, ss_tlast}, {31'd0, (beats == int'(v.len) - 1)});
                if (beats == 0) begin
                    chk("first_beat", ss_tdata, v.exp_first);
                end
                if (beats == int'(v.len) - 1) begin
                    chk("last_beat", ss_tdata, v.exp_last);
                end
                beats++;
            end
            chk("outstanding_le_2", {31'd0, ((reads - beats) <= 2)}, 32'd1);
            pv = ss_tvalid;
            pr = ss_tready;
            pd = ss_tdata;
            pl = ss_tlast;
            if (done) begin
                chk("done_cycle", cyc, v.exp_done);
                fin = 1'b1;
            end else if (cyc >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_timeout: no done after %0d cycles, expected at %0d", cyc, v.exp_done);
                fin = 1'b1;
            end
        end
        chk("read_count", reads, int'(v.len));
        chk("beat_count", beats, int'(v.len));
        @(posedge clk); #1;
        cfg_start = 1'b0;
        ss_tready = 1'b1;
        @(negedge clk);
        chk_idle_outputs("after_done");
    endtask

    initial begin
        vec_t v6;
        int   beats6;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'(i + 1);
        end
        // base, len, ready_mode, mid_start, exp_done, exp_first, exp_last
        vecs[0] = '{12'h000, 16'd4, 0, 0,  7, 32'h1,   32'h4};   // basic, full rate
        vecs[1] = '{12'h000, 16'd4, 1, 0, 13, 32'h1,   32'h4};   // backpressure 1,0,0
        vecs[2] = '{12'h040, 16'd0, 0, 0,  1, 32'h0,   32'h0};   // zero length
        vecs[3] = '{12'hFFC, 16'd2, 0, 0,  5, 32'h400, 32'h1};   // address wrap
        vecs[4] = '{12'h000, 16'd4, 0, 3,  7, 32'h1,   32'h4};   // stray start ignored
        vecs[5] = '{12'h013, 16'd3, 0, 0,  6, 32'h5,   32'h7};   // low bits dropped

        axis_rst      = 1'b1;
        cfg_start     = 1'b0;
        cfg_base_addr = 12'h000;
        cfg_length    = 16'd0;
        ss_tready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        axis_rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Mid-transfer reset: 8-word stream, reset after two accepted beats
        beats6 = 0;
        @(posedge clk); #1;
        cfg_start     = 1'b1;
        cfg_base_addr = 12'h000;
        cfg_length    = 16'd8;
        ss_tready     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            cfg_start = 1'b0;
            @(negedge clk);
            if (ss_tvalid && ss_tready) begin
                beats6++;
                chk("pre_reset_tdata", ss_tdata, 32'(beats6));
            end
        end
        chk("pre_reset_beats", beats6, 2);
        @(posedge clk); #1;
        axis_rst = 1'b1;
        @(posedge clk); #1;
        axis_rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("post_reset_no_done", {31'd0, done}, 32'd0);
            chk("post_reset_no_beat", {31'd0, ss_tvalid}, 32'd0);
            chk("post_reset_no_read", {31'd0, ram_en}, 32'd0);
        end
        v6 = '{12'h100, 16'd3, 0, 0, 6, 32'h41, 32'h43};
        run_vec(v6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
